// File: rtl/crc8_frame_checker_pkg.sv
// Shared frame geometry, FSM encoding and small helpers for the CRC-8 frame checker.
package crc8_frame_checker_pkg;

  localparam int FRAME_LEN   = 10;
  localparam int CRC_IDX     = 8;
  localparam int PAYLOAD_LEN = CRC_IDX;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    TAIL
  } state_t;

  // End-of-frame / abort events, registered into one-cycle pulses.
  typedef struct packed {
    logic good;
    logic bad;
    logic sync;
  } evt_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/crc8_update.sv
// One-byte CRC-8 step, MSB-first, non-reflected; purely combinational.
module crc8_update #(
  parameter logic [7:0] POLYNOMIAL = 8'h07
) (
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] next_crc
);

  logic [8:0][7:0] stage;

  assign stage[0] = crc ^ data;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign stage[i+1] = stage[i][7] ? ({stage[i][6:0], 1'b0} ^ POLYNOMIAL)
                                    : {stage[i][6:0], 1'b0};
  end

  assign next_crc = stage[8];

endmodule

// File: rtl/crc8_frame_checker.sv
// Receives 10-byte frames (8 payload, CRC, trailer), checks the CRC and
// publishes the last good payload plus good/bad/sync pulses and an error count.
module crc8_frame_checker
  import crc8_frame_checker_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INITIAL    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  input  logic        sof_i,
  output logic [63:0] payload_o,
  output logic        frame_valid_o,
  output logic        crc_err_o,
  output logic        sync_err_o,
  output logic [7:0]  err_count_o,
  output logic [3:0]  byte_counter_o
);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  crc, crc_nxt, crc_seed, crc_upd;
  logic [63:0] shadow, shadow_nxt;
  logic        match, match_nxt;
  evt_t        evt, evt_nxt;
  logic [63:0] payload;
  logic [7:0]  errs;

  // A sof byte always restarts the CRC, so the seed is muxed in front of the update.
  assign crc_seed = (data_valid_i && sof_i) ? INITIAL : crc;

  crc8_update #(.POLYNOMIAL(POLYNOMIAL)) u_crc (
    .crc      (crc_seed),
    .data     (data_i),
    .next_crc (crc_upd)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    crc_nxt    = crc;
    shadow_nxt = shadow;
    match_nxt  = match;
    evt_nxt    = '0;
    if (data_valid_i) begin
      if (sof_i) begin
        evt_nxt.sync = (state != IDLE);
        state_nxt    = PAYLOAD;
        cnt_nxt      = 4'd1;
        crc_nxt      = crc_upd;
        shadow_nxt   = {56'h0, data_i};
        match_nxt    = 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          PAYLOAD: begin
            // Shift in so that byte 0 ends up in the top byte after eight bytes.
            shadow_nxt = {shadow[55:0], data_i};
            crc_nxt    = crc_upd;
            cnt_nxt    = cnt + 4'd1;
            if (cnt == 4'(PAYLOAD_LEN - 1)) state_nxt = CHECK;
          end
          CHECK: begin
            match_nxt = (data_i == crc);
            cnt_nxt   = cnt + 4'd1;
            state_nxt = TAIL;
          end
          TAIL: begin
            evt_nxt.good = match;
            evt_nxt.bad  = ~match;
            cnt_nxt      = 4'd0;
            crc_nxt      = INITIAL;
            state_nxt    = IDLE;
          end
          default: begin
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      crc     <= INITIAL;
      shadow  <= '0;
      match   <= 1'b0;
      evt     <= '0;
      payload <= '0;
      errs    <= 8'd0;
    end else begin
      cnt    <= cnt_nxt;
      crc    <= crc_nxt;
      shadow <= shadow_nxt;
      match  <= match_nxt;
      evt    <= evt_nxt;
      if (evt_nxt.good) payload <= shadow;
      if (evt_nxt.bad || evt_nxt.sync) errs <= sat_inc8(errs);
    end
  end

  assign payload_o      = payload;
  assign frame_valid_o  = evt.good;
  assign crc_err_o      = evt.bad;
  assign sync_err_o     = evt.sync;
  assign err_count_o    = errs;
  assign byte_counter_o = cnt;

endmodule

// File: doc/crc8_frame_checker.md
CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

Interface
REQ-001 Parameter: POLYNOMIAL, 8'h07, CRC-8 generator polynomial.
REQ-002 Parameter: INITIAL, 8'hFF, CRC register seed at start of each frame.
REQ-003 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: data_i  input  8  received stream byte.
REQ-006 Port: data_valid_i  input  1  data_i is accepted this cycle.
REQ-007 Port: sof_i  input  1  the accepted byte is frame byte 0; ignored when data_valid_i=0.
REQ-008 Port: payload_o  output  64  last good payload; byte 0 in bits [63:56].
REQ-009 Port: frame_valid_o  output  1  one-cycle pulse: good frame completed.
REQ-010 Port: crc_err_o  output  1  one-cycle pulse: frame completed with CRC mismatch.
REQ-011 Port: sync_err_o  output  1  one-cycle pulse: frame aborted by an early sof_i.
REQ-012 Port: err_count_o  output  8  saturating count of CRC plus sync errors.
REQ-013 Port: byte_counter_o  output  4  index (0..9) of the next expected byte.

Function
REQ-014 Frame SHALL be 10 bytes: bytes 0-7 payload, byte 8 CRC over bytes 0-7, byte 9 trailer (any value, discarded).
REQ-015 CRC SHALL be MSB-first, non-reflected, no final XOR, seeded with INITIAL at byte 0, updated once per accepted payload byte.
REQ-016 FSM states SHALL be IDLE, PAYLOAD, CHECK, TAIL; state changes only on cycles with data_valid_i=1.
REQ-017 IDLE: non-sof bytes discarded; sof byte -> capture as byte 0, go to PAYLOAD, counter=1.
REQ-018 PAYLOAD: capture byte into shadow register; after byte 7 -> CHECK.
REQ-019 CHECK: compare data_i to the computed CRC, latch the match flag -> TAIL.
REQ-020 TAIL: on the trailer byte -> IDLE; the following cycle, pulse frame_valid_o (match) or crc_err_o (mismatch).
REQ-021 payload_o SHALL load from the shadow register in the same cycle frame_valid_o rises; it holds otherwise and never changes on a bad frame.
REQ-022 sof_i accepted in PAYLOAD, CHECK or TAIL SHALL abort the frame, pulse sync_err_o next cycle, reseed the CRC, and treat the byte as byte 0 of a new frame.
REQ-023 data_valid_i=0 gaps of any length SHALL freeze state, counter and CRC.
REQ-024 err_count_o SHALL increment by 1 per crc_err_o or sync_err_o pulse and saturate at 8'hFF; the two pulses are never simultaneous.
REQ-025 Back-to-back frames (sof on the cycle after the trailer) SHALL be accepted with no dead cycle.
REQ-026 byte_counter_o SHALL be 0 in IDLE and equal the next expected byte index otherwise.

Reset
REQ-027 While reset_n=0: state IDLE, counter 0, payload_o 0, all pulses 0, err_count_o 0, CRC register INITIAL.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame and raise no error pulse.

Structure
REQ-029 Frame-length constant (10), CRC byte index (8), and the FSM state enum SHALL live in the shared project package.
REQ-030 The single-byte CRC update SHALL be a combinational sub-module crc8_update (inputs crc, byte; output next crc; POLYNOMIAL parameter).

Verification
REQ-031 Payload 00,01..07, model CRC, trailer 00, continuous valid -> frame_valid_o pulse 1 cycle after trailer, payload_o=64'h0001020304050607.
REQ-032 Same frame with CRC byte bit 0 flipped -> crc_err_o pulse, err_count_o=1, payload_o unchanged.
REQ-033 Good frame with data_valid_i low for 3 cycles between each byte -> identical result to REQ-031.
REQ-034 sof_i at byte 5, then a complete good frame -> sync_err_o pulse, err_count_o=1, then frame_valid_o with the new payload.
REQ-035 300 bad-CRC frames -> err_count_o stops at 8'hFF.
REQ-036 reset_n low at byte 4, then released, then a good frame -> no error pulse, frame_valid_o on the new frame.
